cache_base_ctrl: RTL

//  Control unit for the baseline blocking direct-mapped write-back cache; it drives lab3_cache_CacheBaseDpath.

---
 rtl/cache_pkg.sv | 81 ++++++++
 rtl/cache_valid_array.sv | 32 +++
 rtl/cache_base_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the baseline blocking cache controller:
// FSM states, processor request types and the Moore output decode.
package cache_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TC,
        IN,
        RD,
        WD,
        SP,
        SPW,
        RR,
        RW,
        RU,
        WAIT
    } state_t;

    localparam logic [2:0] REQ_READ  = 3'd0;
    localparam logic [2:0] REQ_WRITE = 3'd1;
    localparam logic [2:0] REQ_INIT  = 3'd2;

    // State-decoded (registered) control outputs.
    typedef struct packed {
        logic memreq_rdy;
        logic memresp_val;
        logic cache_req_val;
        logic cache_resp_rdy;
        logic reg_en_M0;
        logic tarray_en;
        logic tarray_wen;
        logic z6b_sel;
        logic darray_write_mux_sel;
        logic darray_wen;
        logic write_en_sel;
        logic spill_or_refill_sel;
    } moore_t;

    // Values held while reset is asserted: only the processor port looks ready.
    localparam moore_t RESET_OUT = '{memreq_rdy: 1'b1, default: 1'b0};

    // Moore output pattern for a given state.
    function automatic moore_t decode(input state_t s);
        moore_t o;
        o = '0;
        case (s)
            IDLE: begin
                o.memreq_rdy = 1'b1;
                o.reg_en_M0  = 1'b1;
            end
            TC:   o.tarray_en = 1'b1;
            IN: begin
                o.tarray_wen   = 1'b1;
                o.darray_wen   = 1'b1;
                o.write_en_sel = 1'b1;
            end
            RD:   o.tarray_en = 1'b1;
            // Processor write data selected (mux sel left at 0).
            WD:   o.darray_wen = 1'b1;
            SP:   o.cache_req_val = 1'b1;
            SPW:  o.cache_resp_rdy = 1'b1;
            RR: begin
                o.cache_req_val       = 1'b1;
                o.spill_or_refill_sel = 1'b1;
            end
            // Refill data selected; the data-array write itself is handshake-qualified.
            RW: begin
                o.cache_resp_rdy       = 1'b1;
                o.darray_write_mux_sel = 1'b1;
            end
            RU: begin
                o.tarray_wen = 1'b1;
                o.z6b_sel    = 1'b1;
            end
            WAIT: o.memresp_val = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/cache_valid_array.sv
// Per-line valid bits: async clear on reset, clear-all on flush,
// set by index, combinational read on the same index.
module cache_valid_array
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    localparam int IDX_W = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic             clr_all,
    input  logic [IDX_W-1:0] idx,
    output logic             rd_val
);

    logic [NUM_LINES-1:0] valid;

    // Clear-all has priority; it only happens in IDLE, so it never races a set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else if (set_en) begin
            valid[idx] <= 1'b1;
        end
    end

    assign rd_val = valid[idx];

endmodule

// File: rtl/cache_base_ctrl.sv
// Control unit for the baseline blocking direct-mapped write-back cache.
// Sequences tag check, data access, per-word spill/refill and response;
// owns the line valid bits. Dirty and word-count status come from the datapath.
module cache_base_ctrl
    import cache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    localparam int IDX_W = $clog2(NUM_LINES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memreq_val,
    output logic             memreq_rdy,
    input  logic [2:0]       memreq_type,
    input  logic [IDX_W-1:0] memreq_idx,
    output logic             memresp_val,
    input  logic             memresp_rdy,
    output logic             cache_req_val,
    input  logic             cache_req_rdy,
    input  logic             cache_resp_val,
    output logic             cache_resp_rdy,
    input  logic             flush,
    input  logic             tarray_match,
    input  logic             current_dirty,
    input  logic             spill_done,
    input  logic             refill_req_done,
    input  logic             refill_resp_done,
    output logic             reg_en_M0,
    output logic             tarray_en,
    output logic             tarray_wen,
    output logic             z6b_sel,
    output logic             darray_write_mux_sel,
    output logic             darray_wen,
    output logic             write_en_sel,
    output logic             spill_one_word_done,
    output logic             refill_one_word_req_sent,
    output logic             refill_one_word_resp_received,
    output logic             Spill_or_Refill_sel
);

    state_t     state;
    state_t     next_state;
    moore_t     out_q;
    logic [2:0] req_type;
    logic       line_valid;
    logic       hit;
    logic       req_fire;
    logic       is_write;
    logic       spw_fire;
    logic       rr_fire;
    logic       rw_fire;

    cache_valid_array #(.NUM_LINES(NUM_LINES)) u_valid (
        .clk     (clk),
        .reset   (reset),
        .set_en  ((state == IN) || (state == RU)),
        .clr_all ((state == IDLE) && flush && !memreq_val),
        .idx     (memreq_idx),
        .rd_val  (line_valid)
    );

    assign req_fire = (state == IDLE) && memreq_val;
    assign hit      = line_valid && tarray_match;
    assign is_write = (req_type == REQ_WRITE);

    // Handshake-qualified pulses: only while the partner side actually fires.
    assign spw_fire = (state == SPW) && cache_resp_val;
    assign rr_fire  = (state == RR)  && cache_req_rdy;
    assign rw_fire  = (state == RW)  && cache_resp_val;

    // Next-state selection.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (memreq_val) next_state = TC;
            TC: begin
                if (req_type == REQ_INIT)            next_state = IN;
                else if (hit)                        next_state = is_write ? WD : RD;
                else if (line_valid && current_dirty) next_state = SP;
                else                                 next_state = RR;
            end
            IN, RD, WD: next_state = WAIT;
            SP:   if (cache_req_rdy) next_state = SPW;
            SPW:  if (cache_resp_val) next_state = spill_done ? RR : SP;
            RR:   if (cache_req_rdy && refill_req_done) next_state = RW;
            RW:   if (cache_resp_val && refill_resp_done) next_state = RU;
            RU:   next_state = is_write ? WD : RD;
            WAIT: if (memresp_rdy) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register, registered Moore outputs and the latched request type.
    // Outputs are decoded from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            out_q    <= RESET_OUT;
            req_type <= REQ_READ;
        end else begin
            state <= next_state;
            out_q <= decode(next_state);
            if (req_fire) req_type <= memreq_type;
        end
    end

    assign memreq_rdy                    = out_q.memreq_rdy;
    assign memresp_val                   = out_q.memresp_val;
    assign cache_req_val                 = out_q.cache_req_val;
    assign cache_resp_rdy                = out_q.cache_resp_rdy;
    assign reg_en_M0                     = out_q.reg_en_M0;
    assign tarray_en                     = out_q.tarray_en;
    assign tarray_wen                    = out_q.tarray_wen;
    assign z6b_sel                       = out_q.z6b_sel;
    assign darray_write_mux_sel          = out_q.darray_write_mux_sel;
    assign darray_wen                    = out_q.darray_wen | rw_fire;
    assign write_en_sel                  = out_q.write_en_sel;
    assign Spill_or_Refill_sel           = out_q.spill_or_refill_sel;
    assign spill_one_word_done           = spw_fire;
    assign refill_one_word_req_sent      = rr_fire;
    assign refill_one_word_resp_received = rw_fire;

endmodule
